fetch_pc_stage: RTL and testbench
=================================

// Module: fetch_pc_stage
// PURPOSE
//   Instruction-fetch stage that sits directly downstream of the 32-bit next-PC 2:1 mux.
//   - Feeds the mux: pc_plus4 drives mux in1; branch target on in2; branch_taken on s.
//   - Consumes the mux output as next_pc.
//   - Holds the PC register and drives a multi-cycle instruction-memory req/ack handshake.
//   - Produces the IF/ID pipeline register, with freeze (hazard stall) and flush (branch).
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC value loaded on reset
//   PC_STEP    4               increment applied to pc for pc_plus4 / IF/ID pc field
// PORTS
//   clk           in   1    single clock; all state updates on posedge
//   rst           in   1    synchronous, active-high reset
//   freeze        in   1    hazard stall from ID; hold PC and IF/ID
//   branch_taken  in   1    redirect from EX; also drives mux select
//   next_pc       in   32   mux output (pc_plus4 or branch target)
//   pc_plus4      out  32   pc + PC_STEP, combinational, to mux in1
//   imem_req      out  1    instruction-memory request
//   imem_addr     out  32   fetch address (= pc)
//   imem_rdata    in   32   instruction word, valid when imem_ack=1
//   imem_ack      in   1    memory done; may assert in same cycle as imem_req
//   if_id_pc      out  32   registered pc+PC_STEP of fetched instruction
//   if_id_instr   out  32   registered instruction
//   if_id_valid   out  1    IF/ID holds a live instruction
// BEHAVIOUR
//   Reset (rst=1 at posedge) -> pc=RESET_PC; state=S_REQ; kill=0; hold_valid=0;
//     if_id_pc=0; if_id_instr=0; if_id_valid=0.
//   rst has priority over every other input. Any in-flight fetch is abandoned;
//     the ack for it is ignored only if it arrives while rst=1.
//   imem_req=1 in S_REQ, 0 in S_HOLD. imem_addr=pc always.
//     pc is stable while imem_req=1 and imem_ack=0.
//   S_REQ, imem_ack=0:
//     - branch_taken=1: kill<=1, redirect_pc<=next_pc, if_id_valid<=0.
//     - Otherwise no change.
//   S_REQ, imem_ack=1 (priority order):
//     - branch_taken=1: drop word; pc<=next_pc; kill<=0; if_id_valid<=0.
//     - kill=1: drop word; pc<=redirect_pc; kill<=0; IF/ID unchanged.
//     - freeze=1: hold_instr<=imem_rdata; hold_valid<=1; state<=S_HOLD;
//       pc and IF/ID unchanged.
//     - else: if_id_pc<=pc_plus4; if_id_instr<=imem_rdata; if_id_valid<=1; pc<=next_pc.
//   S_HOLD (word buffered):
//     - branch_taken=1: drop buffer; hold_valid<=0; pc<=next_pc; if_id_valid<=0; ->S_REQ.
//     - freeze=1: hold everything.
//     - freeze=0: IF/ID<={pc_plus4, hold_instr, 1}; pc<=next_pc; hold_valid<=0; ->S_REQ.
//   Flush beats freeze: branch_taken=1 always clears if_id_valid, even when freeze=1.
//   Freeze with no branch holds if_id_* bit-exact.
//   Latency: ack at edge N -> instruction visible on if_id_* after edge N.
//   Throughput: with ack tied to req, 1 instruction/cycle.
//   pc arithmetic is mod 2^32; pc=32'hFFFF_FFFC gives pc_plus4=0, no flag.
//   next_pc is only sampled on the edges listed above; it is ignored otherwise.
// TESTING
//   1. Zero-wait memory (ack=req), no stalls, 4 cycles after reset:
//      -> if_id_pc = 4, 8, 12, 16; if_id_valid=1.
//   2. Ack 3 cycles after req -> imem_addr held at 0 for 3 cycles;
//      IF/ID loads {4, instr0} after the ack edge; then addr=4.
//   3. freeze=1 for 2 cycles at ack of pc=8 -> IF/ID frozen, S_HOLD entered;
//      on release IF/ID={12, instr@8} and pc=12.
//   4. branch_taken=1, next_pc=0x100, while ack pending at pc=0x10 ->
//      if_id_valid=0; late ack word dropped; next imem_addr=0x100.
//   5. branch_taken=1 and freeze=1 together -> if_id_valid=0; pc=next_pc;
//      no word retained.
//   6. rst=1 mid-fetch with ack pending and IF/ID valid -> next cycle:
//      pc=RESET_PC, if_id_valid=0, imem_req=1, imem_addr=0.

Source files
------------

// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage
//   Instruction-fetch stage sitting downstream of the 32-bit next-PC 2:1 mux.
//   Holds the PC, runs a multi-cycle instruction-memory req/ack handshake and
//   produces the IF/ID pipeline register with freeze (hazard stall) and flush
//   (taken branch) handling.
//
// Ports
//   clk           in   1   single clock, all state updates on posedge
//   rst           in   1   synchronous active-high reset
//   freeze        in   1   hazard stall from ID; hold PC and IF/ID
//   branch_taken  in   1   redirect from EX (also the mux select)
//   next_pc       in   32  mux output (pc_plus4 or branch target)
//   pc_plus4      out  32  pc + PC_STEP, combinational, to mux in1
//   imem_req      out  1   instruction-memory request
//   imem_addr     out  32  fetch address (= pc)
//   imem_rdata    in   32  instruction word, valid when imem_ack=1
//   imem_ack      in   1   memory done; may assert in the same cycle as imem_req
//   if_id_pc      out  32  registered pc+PC_STEP of the fetched instruction
//   if_id_instr   out  32  registered instruction
//   if_id_valid   out  1   IF/ID holds a live instruction
module fetch_pc_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  // S_REQ: a fetch is outstanding at pc. S_HOLD: the fetched word is parked in
  // hold_instr because ID was frozen when it arrived.
  typedef enum logic {S_REQ, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;

  // Wraps mod 2^32 with no carry flag.
  assign pc_plus4    = pc_q + PC_STEP;
  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == S_REQ);
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    redirect_pc_d = redirect_pc_q;
    hold_instr_d  = hold_instr_q;
    hold_valid_d  = hold_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;

    case (state_q)
      S_REQ: begin
        if (imem_ack) begin
          if (branch_taken) begin
            // Word belongs to the wrong path: drop it and refetch at target.
            pc_d          = next_pc;
            kill_d        = 1'b0;
            if_id_valid_d = 1'b0;
          end else if (kill_q) begin
            // Late ack of a fetch that a branch already overtook: the pc
            // could not move while the request was open, so apply the
            // remembered target now.
            pc_d   = redirect_pc_q;
            kill_d = 1'b0;
          end else if (freeze) begin
            hold_instr_d = imem_rdata;
            hold_valid_d = 1'b1;
            state_d      = S_HOLD;
          end else begin
            if_id_pc_d    = pc_plus4;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = 1'b1;
            pc_d          = next_pc;
          end
        end else if (branch_taken) begin
          // Address must stay stable while the request is pending, so the
          // redirect is recorded and applied when the ack finally arrives.
          kill_d        = 1'b1;
          redirect_pc_d = next_pc;
          if_id_valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          hold_valid_d  = 1'b0;
          pc_d          = next_pc;
          if_id_valid_d = 1'b0;
          state_d       = S_REQ;
        end else if (!freeze) begin
          if_id_pc_d    = pc_plus4;
          if_id_instr_d = hold_instr_q;
          if_id_valid_d = hold_valid_q;
          pc_d          = next_pc;
          hold_valid_d  = 1'b0;
          state_d       = S_REQ;
        end
      end

      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      redirect_pc_q <= 32'h0;
      hold_instr_q  <= 32'h0;
      hold_valid_q  <= 1'b0;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= 32'h0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      redirect_pc_q <= redirect_pc_d;
      hold_instr_q  <= hold_instr_d;
      hold_valid_q  <= hold_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Testbench for fetch_pc_stage: a memory model returns a word derived from
// the address on ack (garbage otherwise); the next-PC mux is modelled here.
// Expected IF/ID contents are queued when the accepting ack is driven and
// popped/compared after the edge that should load them.
module tb_fetch_pc_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  logic        tie;       // 1: ack tied to req (zero-wait memory)
  logic        ack_drv;   // explicit ack when not tied
  logic [31:0] br_target;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } txn_t;

  txn_t sb[$];
  txn_t exp_t;
  int   total;
  int   passed;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_ack   = tie ? imem_req : ack_drv;
  assign imem_rdata = imem_ack ? mk(imem_addr) : 32'hDEAD_BEEF;
  assign next_pc    = branch_taken ? br_target : pc_plus4;

  fetch_pc_stage #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .next_pc      (next_pc),
    .pc_plus4     (pc_plus4),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; tie = 1'b0; ack_drv = 1'b0; freeze = 1'b0;
    branch_taken = 1'b0; br_target = 32'h0;
    sb.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", if_id_valid); else passed++;
    total++; if (if_id_pc !== 32'h0) $display("FAIL reset_if_id_pc: got %h required 0", if_id_pc); else passed++;
    total++; if (if_id_instr !== 32'h0) $display("FAIL reset_if_id_instr: got %h required 0", if_id_instr); else passed++;
    total++; if (imem_req !== 1'b1) $display("FAIL reset_req: got %b required 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h required 0", imem_addr); else passed++;
    total++; if (pc_plus4 !== 32'h4) $display("FAIL reset_pc_plus4: got %h required 4", pc_plus4); else passed++;
    $display("txn reset done");
  endtask

  task automatic test_zero_wait;
    logic [31:0] p;
    do_reset();
    tie = 1'b1;
    p = 32'h0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{pc: p + 32'd4, instr: mk(p)});
      step();
      total++;
      if (sb.size() == 0) $display("FAIL zero_wait_sb: queue empty");
      else begin
        exp_t = sb.pop_front();
        if (if_id_valid !== 1'b1 || if_id_pc !== exp_t.pc || if_id_instr !== exp_t.instr)
          $display("FAIL zero_wait_txn: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                   if_id_valid, if_id_pc, if_id_instr, exp_t.pc, exp_t.instr);
        else begin passed++; $display("txn zero_wait pc=%h instr=%h", if_id_pc, if_id_instr); end
      end
      p = p + 32'd4;
      total++; if (imem_addr !== p) $display("FAIL zero_wait_addr: got %h required %h", imem_addr, p); else passed++;
    end
    tie = 1'b0;
  endtask

  task automatic test_wait_states;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || if_id_valid !== 1'b0)
        $display("FAIL wait_hold: got addr=%h req=%b v=%b required addr=0 req=1 v=0", imem_addr, imem_req, if_id_valid);
      else passed++;
    end
    ack_drv = 1'b1;
    sb.push_back('{pc: 32'h4, instr: mk(32'h0)});
    step();
    ack_drv = 1'b0;
    total++;
    if (sb.size() == 0) $display("FAIL wait_sb: queue empty");
    else begin
      exp_t = sb.pop_front();
      if (if_id_valid !== 1'b1 || if_id_pc !== exp_t.pc || if_id_instr !== exp_t.instr)
        $display("FAIL wait_txn: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                 if_id_valid, if_id_pc, if_id_instr, exp_t.pc, exp_t.instr);
      else begin passed++; $display("txn wait pc=%h instr=%h", if_id_pc, if_id_instr); end
    end
    total++; if (imem_addr !== 32'h4) $display("FAIL wait_next_addr: got %h required 4", imem_addr); else passed++;
  endtask

  task automatic test_freeze;
    do_reset();
    tie = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{pc: 32'(i * 4 + 4), instr: mk(32'(i * 4))});
      step();
      total++;
      if (sb.size() == 0) $display("FAIL freeze_pre_sb: queue empty");
      else begin
        exp_t = sb.pop_front();
        if (if_id_valid !== 1'b1 || if_id_pc !== exp_t.pc || if_id_instr !== exp_t.instr)
          $display("FAIL freeze_pre_txn: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                   if_id_valid, if_id_pc, if_id_instr, exp_t.pc, exp_t.instr);
        else begin passed++; $display("txn freeze_pre pc=%h instr=%h", if_id_pc, if_id_instr); end
      end
    end
    freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || if_id_instr !== mk(32'h4))
        $display("FAIL freeze_hold_ifid: got v=%b pc=%h instr=%h required v=1 pc=8 instr=%h",
                 if_id_valid, if_id_pc, if_id_instr, mk(32'h4));
      else passed++;
      total++; if (imem_req !== 1'b0 || imem_addr !== 32'h8)
        $display("FAIL freeze_hold_req: got req=%b addr=%h required req=0 addr=8", imem_req, imem_addr);
      else passed++;
    end
    freeze = 1'b0;
    sb.push_back('{pc: 32'hC, instr: mk(32'h8)});
    step();
    tie = 1'b0;
    total++;
    if (sb.size() == 0) $display("FAIL freeze_rel_sb: queue empty");
    else begin
      exp_t = sb.pop_front();
      if (if_id_valid !== 1'b1 || if_id_pc !== exp_t.pc || if_id_instr !== exp_t.instr)
        $display("FAIL freeze_rel_txn: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                 if_id_valid, if_id_pc, if_id_instr, exp_t.pc, exp_t.instr);
      else begin passed++; $display("txn freeze_release pc=%h instr=%h", if_id_pc, if_id_instr); end
    end
    total++; if (imem_addr !== 32'hC) $display("FAIL freeze_rel_addr: got %h required c", imem_addr); else passed++;
  endtask

  task automatic test_branch_pending;
    do_reset();
    tie = 1'b1;
    repeat (4) step();
    tie = 1'b0; ack_drv = 1'b0;
    step();
    branch_taken = 1'b1; br_target = 32'h100;
    step();
    branch_taken = 1'b0;
    total++; if (if_id_valid !== 1'b0) $display("FAIL br_pend_flush: got v=%b required 0", if_id_valid); else passed++;
    total++; if (imem_addr !== 32'h10 || imem_req !== 1'b1)
      $display("FAIL br_pend_addr_stable: got addr=%h req=%b required addr=10 req=1", imem_addr, imem_req);
    else passed++;
    step();
    ack_drv = 1'b1;
    step();
    ack_drv = 1'b0;
    total++; if (if_id_valid !== 1'b0 || if_id_pc !== 32'h10)
      $display("FAIL br_late_drop: got v=%b pc=%h required v=0 pc=10", if_id_valid, if_id_pc);
    else passed++;
    total++; if (imem_addr !== 32'h100) $display("FAIL br_redirect_addr: got %h required 100", imem_addr); else passed++;
    tie = 1'b1;
    sb.push_back('{pc: 32'h104, instr: mk(32'h100)});
    step();
    tie = 1'b0;
    total++;
    if (sb.size() == 0) $display("FAIL br_pend_sb: queue empty");
    else begin
      exp_t = sb.pop_front();
      if (if_id_valid !== 1'b1 || if_id_pc !== exp_t.pc || if_id_instr !== exp_t.instr)
        $display("FAIL br_target_txn: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                 if_id_valid, if_id_pc, if_id_instr, exp_t.pc, exp_t.instr);
      else begin passed++; $display("txn branch_target pc=%h instr=%h", if_id_pc, if_id_instr); end
    end
  endtask

  task automatic test_branch_freeze;
    do_reset();
    tie = 1'b1;
    step();
    // Branch and freeze together on an acked fetch.
    branch_taken = 1'b1; freeze = 1'b1; br_target = 32'h200;
    step();
    branch_taken = 1'b0;
    total++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200)
      $display("FAIL brfrz_req: got v=%b req=%b addr=%h required v=0 req=1 addr=200", if_id_valid, imem_req, imem_addr);
    else passed++;
    // Park the word at 0x200, then branch+freeze while it is parked.
    step();
    total++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0)
      $display("FAIL brfrz_park: got req=%b v=%b required req=0 v=0", imem_req, if_id_valid);
    else passed++;
    branch_taken = 1'b1; br_target = 32'h300;
    step();
    branch_taken = 1'b0; freeze = 1'b0;
    total++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300)
      $display("FAIL brfrz_hold: got v=%b req=%b addr=%h required v=0 req=1 addr=300", if_id_valid, imem_req, imem_addr);
    else passed++;
    sb.push_back('{pc: 32'h304, instr: mk(32'h300)});
    step();
    tie = 1'b0;
    total++;
    if (sb.size() == 0) $display("FAIL brfrz_sb: queue empty");
    else begin
      exp_t = sb.pop_front();
      if (if_id_valid !== 1'b1 || if_id_pc !== exp_t.pc || if_id_instr !== exp_t.instr)
        $display("FAIL brfrz_txn: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                 if_id_valid, if_id_pc, if_id_instr, exp_t.pc, exp_t.instr);
      else begin passed++; $display("txn branch_freeze pc=%h instr=%h", if_id_pc, if_id_instr); end
    end
  endtask

  task automatic test_reset_midfetch;
    do_reset();
    tie = 1'b1;
    step();
    tie = 1'b0; ack_drv = 1'b0;
    step();
    rst = 1'b1; ack_drv = 1'b1;
    step();
    rst = 1'b0; ack_drv = 1'b0;
    total++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0 || if_id_pc !== 32'h0)
      $display("FAIL rst_mid: got v=%b req=%b addr=%h ifpc=%h required v=0 req=1 addr=0 ifpc=0",
               if_id_valid, imem_req, imem_addr, if_id_pc);
    else passed++;
    tie = 1'b1;
    sb.push_back('{pc: 32'h4, instr: mk(32'h0)});
    step();
    tie = 1'b0;
    total++;
    if (sb.size() == 0) $display("FAIL rst_mid_sb: queue empty");
    else begin
      exp_t = sb.pop_front();
      if (if_id_valid !== 1'b1 || if_id_pc !== exp_t.pc || if_id_instr !== exp_t.instr)
        $display("FAIL rst_mid_txn: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                 if_id_valid, if_id_pc, if_id_instr, exp_t.pc, exp_t.instr);
      else begin passed++; $display("txn after_reset pc=%h instr=%h", if_id_pc, if_id_instr); end
    end
  endtask

  task automatic test_wrap;
    do_reset();
    tie = 1'b1;
    branch_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0)
      $display("FAIL wrap_pc_plus4: got addr=%h pc_plus4=%h required addr=fffffffc pc_plus4=0", imem_addr, pc_plus4);
    else passed++;
    sb.push_back('{pc: 32'h0, instr: mk(32'hFFFF_FFFC)});
    step();
    tie = 1'b0;
    total++;
    if (sb.size() == 0) $display("FAIL wrap_sb: queue empty");
    else begin
      exp_t = sb.pop_front();
      if (if_id_valid !== 1'b1 || if_id_pc !== exp_t.pc || if_id_instr !== exp_t.instr)
        $display("FAIL wrap_txn: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                 if_id_valid, if_id_pc, if_id_instr, exp_t.pc, exp_t.instr);
      else begin passed++; $display("txn wrap pc=%h instr=%h", if_id_pc, if_id_instr); end
    end
    total++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr: got %h required 0", imem_addr); else passed++;
  endtask

  initial begin
    total = 0; passed = 0;
    rst = 1'b1; tie = 1'b0; ack_drv = 1'b0; freeze = 1'b0;
    branch_taken = 1'b0; br_target = 32'h0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_freeze();
    test_branch_pending();
    test_branch_freeze();
    test_reset_midfetch();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
